alu_decode_stage: RTL and testbench

Decode/issue stage feeding `alu_core`: accepts fetched instructions with a valid/ready handshake, decodes RV32I into `aluOP` plus selected operands, and presents them registered to the execute stage. It sits between fetch/register-file read and execute. A 2-entry skid buffer keeps `in_ready` registered, so execute backpressure never combinationally reaches fetch.

---
 rtl/alu_decode_stage_pkg.sv | 73 +++++++
 rtl/alu_decode_stage_imm_gen.sv | 25 ++
 rtl/alu_decode_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_decode_stage_pkg.sv
// Shared constants and types for the RV32I decode/issue stage:
// opcodes, ALU/branch op codes, skid-buffer states and the issued payload.
package alu_decode_stage_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU / branch op codes, {alt, funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1000;
    localparam logic [3:0] ALU_BNE  = 4'b1001;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skidState_e;

    // Fully decoded instruction as handed to execute
    typedef struct packed {
        logic [31:0] aluIn1;
        logic [31:0] aluIn2;
        logic [3:0]  aluOP;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic        isBranch;
        logic        isJump;
        logic        isLoad;
        logic        isStore;
        logic        illegal;
    } exPayload_t;

    // R-type legality: base funct7 for every funct3, alt funct7 only for SUB/SRA
    function automatic logic opFunct7Legal(input logic [6:0] funct7, input logic [2:0] funct3);
        logic ok;
        if (funct7 == FUNCT7_BASE) begin
            ok = 1'b1;
        end else if (funct7 == FUNCT7_ALT) begin
            ok = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Combinational RV32I immediate generator (I/S/B/U/J), sign-extended to 32 bits.
// Opcodes without an immediate produce zero.
module alu_imm_gen
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Select the immediate format from the major opcode
    always_comb begin
        imm = 32'd0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:                      imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:                     imm = {{19{instr[31]}}, instr[31], instr[7],
                                                   instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:             imm = {instr[31:12], 12'd0};
            OPC_JAL:                        imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                                   instr[20], instr[30:21], 1'b0};
            default:                        imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage. Decodes at acceptance and holds up to two fully
// decoded payloads (main + skid) so in_ready is a pure function of state.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_aluIn1,
    output logic [31:0] ex_aluIn2,
    output logic [3:0]  ex_aluOP,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic        ex_wen,
    output logic        ex_is_branch,
    output logic        ex_is_jump,
    output logic        ex_is_load,
    output logic        ex_is_store,
    output logic        ex_illegal
);

    logic [31:0] imm_s;
    logic [6:0]  funct7_s;
    logic [2:0]  funct3_s;
    logic        illegal_s;
    logic        writes_s;
    exPayload_t  dec_s;
    exPayload_t  main_r;
    exPayload_t  skid_r;
    skidState_e  state_r;
    skidState_e  nextState_s;
    logic        exValid_r;
    logic        inReady_r;
    logic        acc_s;
    logic        cons_s;
    logic        loadMainNew_s;
    logic        loadMainSkid_s;
    logic        loadSkid_s;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign funct7_s = in_instr[31:25];
    assign funct3_s = in_instr[14:12];

    alu_imm_gen u_immGen (
        .instr (in_instr),
        .imm   (imm_s)
    );

    // Decode the offered instruction into an issue payload
    always_comb begin
        dec_s          = '0;
        dec_s.pc       = in_pc;
        dec_s.imm      = imm_s;
        dec_s.rd       = in_instr[11:7];
        dec_s.aluIn1   = rs1_data;
        dec_s.aluIn2   = imm_s;
        dec_s.aluOP    = ALU_ADD;
        illegal_s      = 1'b0;
        writes_s       = 1'b0;
        case (in_instr[6:0])
            OPC_OP: begin
                dec_s.aluOP  = {funct7_s[5], funct3_s};
                dec_s.aluIn2 = rs2_data;
                writes_s     = 1'b1;
                illegal_s    = !opFunct7Legal(funct7_s, funct3_s);
            end
            OPC_OP_IMM: begin
                writes_s = 1'b1;
                if (funct3_s == 3'b101) begin
                    dec_s.aluOP = {funct7_s[5], funct3_s};
                    illegal_s   = (funct7_s != FUNCT7_BASE) && (funct7_s != FUNCT7_ALT);
                end else if (funct3_s == 3'b001) begin
                    dec_s.aluOP = {1'b0, funct3_s};
                    illegal_s   = (funct7_s != FUNCT7_BASE);
                end else begin
                    dec_s.aluOP = {1'b0, funct3_s};
                    illegal_s   = 1'b0;
                end
            end
            OPC_LOAD: begin
                dec_s.isLoad = 1'b1;
                writes_s     = 1'b1;
            end
            OPC_STORE: begin
                dec_s.isStore = 1'b1;
            end
            OPC_BRANCH: begin
                dec_s.aluOP    = {1'b1, funct3_s};
                dec_s.aluIn2   = rs2_data;
                dec_s.isBranch = 1'b1;
            end
            OPC_JAL: begin
                dec_s.aluIn1 = in_pc;
                dec_s.isJump = 1'b1;
                writes_s     = 1'b1;
            end
            OPC_JALR: begin
                dec_s.isJump = 1'b1;
                writes_s     = 1'b1;
            end
            OPC_LUI: begin
                dec_s.aluIn1 = 32'd0;
                writes_s     = 1'b1;
            end
            OPC_AUIPC: begin
                dec_s.aluIn1 = in_pc;
                writes_s     = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        // Illegal words still issue, but only as "illegal"
        if (illegal_s) begin
            dec_s.isBranch = 1'b0;
            dec_s.isJump   = 1'b0;
            dec_s.isLoad   = 1'b0;
            dec_s.isStore  = 1'b0;
        end else begin
            dec_s.isBranch = dec_s.isBranch;
        end
        dec_s.illegal = illegal_s;
        dec_s.wen     = writes_s && !illegal_s && (dec_s.rd != 5'd0);
    end

    assign acc_s  = in_valid & inReady_r;
    assign cons_s = exValid_r & ex_ready;

    // Skid-buffer occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next state and payload-move controls; flush overrides any handshake
    always_comb begin
        nextState_s    = state_r;
        loadMainNew_s  = 1'b0;
        loadMainSkid_s = 1'b0;
        loadSkid_s     = 1'b0;
        if (flush) begin
            nextState_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        nextState_s   = ST_ONE;
                        loadMainNew_s = 1'b1;
                    end else begin
                        nextState_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && cons_s) begin
                        nextState_s   = ST_ONE;
                        loadMainNew_s = 1'b1;
                    end else if (acc_s) begin
                        nextState_s = ST_TWO;
                        loadSkid_s  = 1'b1;
                    end else if (cons_s) begin
                        nextState_s = ST_EMPTY;
                    end else begin
                        nextState_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (cons_s) begin
                        nextState_s    = ST_ONE;
                        loadMainSkid_s = 1'b1;
                    end else begin
                        nextState_s = ST_TWO;
                    end
                end
                default: begin
                    nextState_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs registered from the next state so neither is combinational
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exValid_r <= 1'b0;
            inReady_r <= 1'b1;
        end else begin
            exValid_r <= (nextState_s != ST_EMPTY);
            inReady_r <= (nextState_s != ST_TWO);
        end
    end

    // Main payload register: loads a new decode or the promoted skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r <= '0;
        end else if (loadMainNew_s) begin
            main_r <= dec_s;
        end else if (loadMainSkid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid payload register: captures a decode while main is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_r <= '0;
        end else if (loadSkid_s) begin
            skid_r <= dec_s;
        end else begin
            skid_r <= skid_r;
        end
    end

    assign in_ready     = inReady_r;
    assign ex_valid     = exValid_r;
    assign ex_aluIn1    = main_r.aluIn1;
    assign ex_aluIn2    = main_r.aluIn2;
    assign ex_aluOP     = main_r.aluOP;
    assign ex_pc        = main_r.pc;
    assign ex_imm       = main_r.imm;
    assign ex_rd        = main_r.rd;
    assign ex_wen       = main_r.wen;
    assign ex_is_branch = main_r.isBranch;
    assign ex_is_jump   = main_r.isJump;
    assign ex_is_load   = main_r.isLoad;
    assign ex_is_store  = main_r.isStore;
    assign ex_illegal   = main_r.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: a decode vector table plus hand-written
// backpressure, flush and asynchronous-reset sequences.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [31:0] ex_aluIn1;
    logic [31:0] ex_aluIn2;
    logic [3:0]  ex_aluOP;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_is_load;
    logic        ex_is_store;
    logic        ex_illegal;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic [4:0]  flags;   // {branch, jump, load, store, illegal}
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    alu_decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_aluIn1    (ex_aluIn1),
        .ex_aluIn2    (ex_aluIn2),
        .ex_aluOP     (ex_aluOP),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_wen       (ex_wen),
        .ex_is_branch (ex_is_branch),
        .ex_is_jump   (ex_is_jump),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_illegal   (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    // ADDI xk, x0, k
    function automatic logic [31:0] addiK(input logic [4:0] k);
        return {7'd0, k, 5'd0, 3'b000, k, 7'b0010011};
    endfunction

    task automatic checkVec(input int i);
        chk($sformatf("v%0d valid", i), {31'd0, ex_valid}, 32'd1);
        chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
        chk($sformatf("v%0d aluOP", i), {28'd0, ex_aluOP}, {28'd0, vecs[i].op});
        chk($sformatf("v%0d aluIn1", i), ex_aluIn1, vecs[i].in1);
        chk($sformatf("v%0d aluIn2", i), ex_aluIn2, vecs[i].in2);
        chk($sformatf("v%0d imm", i), ex_imm, vecs[i].imm);
        chk($sformatf("v%0d pc", i), ex_pc, vecs[i].pc);
        chk($sformatf("v%0d rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
        chk($sformatf("v%0d wen", i), {31'd0, ex_wen}, {31'd0, vecs[i].wen});
        chk($sformatf("v%0d flags", i),
            {27'd0, ex_is_branch, ex_is_jump, ex_is_load, ex_is_store, ex_illegal},
            {27'd0, vecs[i].flags});
    endtask

    task automatic checkCleared(input string tag);
        chk({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " aluOP"}, {28'd0, ex_aluOP}, 32'd0);
        chk({tag, " aluIn1"}, ex_aluIn1, 32'd0);
        chk({tag, " aluIn2"}, ex_aluIn2, 32'd0);
        chk({tag, " pc"}, ex_pc, 32'd0);
        chk({tag, " imm"}, ex_imm, 32'd0);
        chk({tag, " rd"}, {27'd0, ex_rd}, 32'd0);
        chk({tag, " wen"}, {31'd0, ex_wen}, 32'd0);
        chk({tag, " flags"},
            {27'd0, ex_is_branch, ex_is_jump, ex_is_load, ex_is_store, ex_illegal}, 32'd0);
    endtask

    initial begin
        //          instr         pc            rs1           rs2           op     in1           in2           imm           rd     wen   flags
        vecs[0]  = '{32'hFFB10093, 32'h00000100, 32'd10,       32'd0,        4'h0, 32'd10,       32'hFFFFFFFB, 32'hFFFFFFFB, 5'd1,  1'b1, 5'b00000}; // ADDI x1,x2,-5
        vecs[1]  = '{32'h4041D193, 32'h00000104, 32'h80000000, 32'd0,        4'hD, 32'h80000000, 32'h00000404, 32'h00000404, 5'd3,  1'b1, 5'b00000}; // SRAI x3,x3,4
        vecs[2]  = '{32'h0020C463, 32'h00000108, 32'd3,        32'd7,        4'hC, 32'd3,        32'd7,        32'd8,        5'd8,  1'b0, 5'b10000}; // BLT x1,x2,+8
        vecs[3]  = '{32'h123452B7, 32'h0000010C, 32'h00000055, 32'd0,        4'h0, 32'd0,        32'h12345000, 32'h12345000, 5'd5,  1'b1, 5'b00000}; // LUI x5
        vecs[4]  = '{32'hFFFFF317, 32'h00001000, 32'h00000077, 32'd0,        4'h0, 32'h00001000, 32'hFFFFF000, 32'hFFFFF000, 5'd6,  1'b1, 5'b00000}; // AUIPC x6
        vecs[5]  = '{32'hFFDFF0EF, 32'h00000200, 32'd9,        32'd0,        4'h0, 32'h00000200, 32'hFFFFFFFC, 32'hFFFFFFFC, 5'd1,  1'b1, 5'b01000}; // JAL x1,-4
        vecs[6]  = '{32'h00008067, 32'h00000204, 32'h00000400, 32'd0,        4'h0, 32'h00000400, 32'd0,        32'd0,        5'd0,  1'b0, 5'b01000}; // JALR x0,0(x1)
        vecs[7]  = '{32'hFF812383, 32'h00000208, 32'h00001000, 32'd0,        4'h0, 32'h00001000, 32'hFFFFFFF8, 32'hFFFFFFF8, 5'd7,  1'b1, 5'b00100}; // LW x7,-8(x2)
        vecs[8]  = '{32'h00512623, 32'h0000020C, 32'h00002000, 32'hDEADBEEF, 4'h0, 32'h00002000, 32'd12,       32'd12,       5'd12, 1'b0, 5'b00010}; // SW x5,12(x2)
        vecs[9]  = '{32'h402081B3, 32'h00000210, 32'd9,        32'd4,        4'h8, 32'd9,        32'd4,        32'd0,        5'd3,  1'b1, 5'b00000}; // SUB x3,x1,x2
        vecs[10] = '{32'h00000000, 32'h00000214, 32'h00000011, 32'h00000022, 4'h0, 32'h00000011, 32'd0,        32'd0,        5'd0,  1'b0, 5'b00001}; // all-zero word
        vecs[11] = '{32'h402091B3, 32'h00000218, 32'd5,        32'd6,        4'h9, 32'd5,        32'd6,        32'd0,        5'd3,  1'b0, 5'b00001}; // SLL with alt funct7
        vecs[12] = '{32'h40009093, 32'h0000021C, 32'd5,        32'd0,        4'h1, 32'd5,        32'h00000400, 32'h00000400, 5'd1,  1'b0, 5'b00001}; // SLLI bad funct7
        vecs[13] = '{32'h00208033, 32'h00000220, 32'd1,        32'd2,        4'h0, 32'd1,        32'd2,        32'd0,        5'd0,  1'b0, 5'b00000}; // ADD x0,x1,x2

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkCleared("reset");

        // Decode table at full throughput: offer vector i, check vector i-1
        ex_ready = 1'b1;
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) begin
                checkVec(i - 1);
            end
            if (i < NV) begin
                offer(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            end else begin
                in_valid = 1'b0;
            end
            if (i == 0) begin
                #1;
                chk("rs1_addr", {27'd0, rs1_addr}, 32'd2);
                chk("rs2_addr", {27'd0, rs2_addr}, 32'd27);
            end
            @(negedge clk);
        end
        chk("drain valid", {31'd0, ex_valid}, 32'd0);

        // Backpressure: three offers, two accepted, then drain in order
        ex_ready = 1'b0;
        offer(addiK(5'd1), 32'h300, 32'd0, 32'd0);
        @(negedge clk);
        chk("bp1 in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp1 valid", {31'd0, ex_valid}, 32'd1);
        chk("bp1 rd", {27'd0, ex_rd}, 32'd1);
        offer(addiK(5'd2), 32'h304, 32'd0, 32'd0);
        @(negedge clk);
        chk("bp2 in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp2 rd", {27'd0, ex_rd}, 32'd1);
        offer(addiK(5'd3), 32'h308, 32'd0, 32'd0);
        @(negedge clk);
        chk("bp3 in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp3 rd stable", {27'd0, ex_rd}, 32'd1);
        chk("bp3 in2 stable", ex_aluIn2, 32'd1);
        chk("bp3 pc stable", ex_pc, 32'h300);
        ex_ready = 1'b1;
        @(negedge clk);
        chk("bp4 rd", {27'd0, ex_rd}, 32'd2);
        chk("bp4 pc", ex_pc, 32'h304);
        chk("bp4 valid", {31'd0, ex_valid}, 32'd1);
        chk("bp4 in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp5 rd", {27'd0, ex_rd}, 32'd3);
        chk("bp5 pc", ex_pc, 32'h308);
        chk("bp5 valid", {31'd0, ex_valid}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp6 valid", {31'd0, ex_valid}, 32'd0);

        // Flush while full with a simultaneous offer
        ex_ready = 1'b0;
        offer(addiK(5'd4), 32'h400, 32'd0, 32'd0);
        @(negedge clk);
        offer(addiK(5'd5), 32'h404, 32'd0, 32'd0);
        @(negedge clk);
        chk("fl full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        offer(addiK(5'd6), 32'h408, 32'd0, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl valid", {31'd0, ex_valid}, 32'd0);
        chk("fl in_ready", {31'd0, in_ready}, 32'd1);
        ex_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("fl after%0d", c), {31'd0, ex_valid}, 32'd0);
        end

        // Illegal all-zero word, then asynchronous reset mid-stream
        ex_ready = 1'b0;
        offer(32'h00000000, 32'h500, 32'h11, 32'h22);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill valid", {31'd0, ex_valid}, 32'd1);
        chk("ill flag", {31'd0, ex_illegal}, 32'd1);
        chk("ill wen", {31'd0, ex_wen}, 32'd0);
        chk("ill pc", ex_pc, 32'h500);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("async rst");
        offer(vecs[0].instr, vecs[0].pc, vecs[0].rs1, vecs[0].rs2);
        ex_ready = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post rst valid", {31'd0, ex_valid}, 32'd1);
        chk("post rst rd", {27'd0, ex_rd}, 32'd1);
        chk("post rst in1", ex_aluIn1, 32'd10);
        in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
